// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, issues imem requests,
// rides out memory misses, applies branch redirects and hazard stalls, and freezes on HLT.
module fetch_stage #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = 16'h0000,
    parameter logic [WIDTH-1:0] NOP_INSTR = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] imem_addr,
    output logic             imem_req,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             imem_rdy,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    output logic [WIDTH-1:0] ifid_instr,
    output logic [WIDTH-1:0] ifid_pc2,
    output logic             ifid_valid,
    output logic             halted,
    output logic [15:0]      miss_cycles,
    output logic [1:0]       dbg_state
);

    // Memory handshake: a word is taken only in a cycle where imem_req and imem_rdy are both
    // high and no branch redirect is present; imem_data is ignored in every other cycle.
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc2_q, pc2_d;
    logic             valid_q, valid_d;
    logic [15:0]      miss_q, miss_d;
    logic [WIDTH-1:0] pc_plus2;
    logic             is_hlt;

    assign pc_plus2 = pc_q + WIDTH'(2);
    assign is_hlt   = (imem_data[WIDTH-1:WIDTH-4] == 4'b1111);

    assign imem_addr   = pc_q;
    assign imem_req    = (state_q != ST_HALTED) && !stall;
    assign halted      = (state_q == ST_HALTED);
    assign ifid_instr  = instr_q;
    assign ifid_pc2    = pc2_q;
    assign ifid_valid  = valid_q;
    assign miss_cycles = miss_q;
    assign dbg_state   = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc2_q   <= '0;
            valid_q <= 1'b0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc2_q   <= pc2_d;
            valid_q <= valid_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc2_d   = pc2_q;
        valid_d = valid_q;
        miss_d  = miss_q;

        if (br_taken) begin
            // Redirect wins over stall and discards any word returned this cycle.
            pc_d    = {br_target[WIDTH-1:1], 1'b0};
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            state_d = ST_FETCH;
        end else if (stall) begin
            state_d = state_q;
        end else if (state_q == ST_HALTED) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (imem_rdy) begin
            instr_d = imem_data;
            pc2_d   = pc_plus2;
            valid_d = 1'b1;
            if (is_hlt) begin
                state_d = ST_HALTED;
            end else begin
                pc_d    = pc_plus2;
                state_d = ST_FETCH;
            end
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            state_d = ST_WAIT;
            miss_d  = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;
        end
    end

endmodule
